// File: rtl/rover_location_finder.sv
// Ultrasound sweep controller: collects one distance code per transducer, keeps the
// nearest valid echo and hands it to the display writer for two vsync periods.
module rover_location_finder #(
  parameter int NUM_SENSORS    = 12,
  parameter int TIMEOUT_CYCLES = 650000,
  parameter int MIN_VALID      = 1,
  parameter int MAX_VALID      = 254
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        sample_valid,
  input  logic [7:0]  sample_distance,
  input  logic [3:0]  sample_index,
  input  logic        vsync,
  output logic [11:0] location,
  output logic        new_data,
  output logic        busy,
  output logic        no_target,
  output logic        sample_error
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0]      LAST_COUNT = 5'(NUM_SENSORS);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, PUBLISH, HOLD} state_t;

  state_t          state;
  logic [4:0]      count;
  logic [TO_W-1:0] tcnt;
  logic [7:0]      best_dist;
  logic [3:0]      best_idx;
  logic            found;
  logic            vsync_prev;
  logic            hold_edge;
  logic            vsync_rise;
  logic            index_ok;

  function automatic logic is_echo(input logic [7:0] d);
    return (int'(d) >= MIN_VALID) && (int'(d) <= MAX_VALID);
  endfunction

  assign vsync_rise = vsync & ~vsync_prev;
  // Indices at or beyond NUM_SENSORS can never equal a live count, so they mismatch too.
  assign index_ok   = ({1'b0, sample_index} == count);
  assign busy       = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      tcnt         <= '0;
      best_dist    <= 8'hFF;
      best_idx     <= '0;
      found        <= 1'b0;
      vsync_prev   <= 1'b0;
      hold_edge    <= 1'b0;
      location     <= 12'h000;
      new_data     <= 1'b0;
      no_target    <= 1'b0;
      sample_error <= 1'b0;
    end else begin
      vsync_prev <= vsync;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SWEEP;
            count        <= '0;
            tcnt         <= '0;
            best_dist    <= 8'hFF;
            best_idx     <= '0;
            found        <= 1'b0;
            no_target    <= 1'b0;
            sample_error <= 1'b0;
          end
        end
        SWEEP: begin
          if (count == LAST_COUNT) begin
            state <= PUBLISH;
          end else if (sample_valid) begin
            count <= count + 5'd1;
            tcnt  <= '0;
            if (!index_ok) begin
              sample_error <= 1'b1;
            end else if (is_echo(sample_distance) && (sample_distance < best_dist)) begin
              best_dist <= sample_distance;
              best_idx  <= sample_index;
              found     <= 1'b1;
            end
          end else if (tcnt == TO_LAST) begin
            sample_error <= 1'b1;
            state        <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        PUBLISH: begin
          if (found) begin
            location  <= {best_idx, best_dist};
            new_data  <= 1'b1;
            hold_edge <= 1'b0;
            state     <= HOLD;
          end else begin
            no_target <= 1'b1;
            state     <= IDLE;
          end
        end
        HOLD: begin
          // The writer samples on vsync; waiting for a second edge guarantees a full frame sees the flag.
          if (vsync_rise) begin
            if (hold_edge) begin
              new_data <= 1'b0;
              state    <= IDLE;
            end else begin
              hold_edge <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rover_location_finder.sv
// Directed bench for rover_location_finder with a scoreboard that checks every
// published location and its arrival cycle.
module tb_rover_location_finder;

  localparam int NS = 12;
  localparam int TO = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        sample_valid;
  logic [7:0]  sample_distance;
  logic [3:0]  sample_index;
  logic        vsync;
  logic [11:0] location;
  logic        new_data;
  logic        busy;
  logic        no_target;
  logic        sample_error;

  rover_location_finder #(
    .NUM_SENSORS(NS), .TIMEOUT_CYCLES(TO), .MIN_VALID(1), .MAX_VALID(254)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .sample_valid(sample_valid),
    .sample_distance(sample_distance), .sample_index(sample_index), .vsync(vsync),
    .location(location), .new_data(new_data), .busy(busy),
    .no_target(no_target), .sample_error(sample_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int last_edge = 0;

  typedef struct {
    logic [11:0] loc;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic nd_prev = 1'b0;

  logic [7:0] dist_v[NS];
  logic [3:0] idx_v[NS];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising new_data must match the oldest pending expectation.
  always @(negedge clock) begin
    if (new_data === 1'b1 && nd_prev !== 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_publish: location %h with no pending sweep", location);
      end else begin
        mon_e = sb.pop_front();
        if (location !== mon_e.loc || cyc != mon_e.due) begin
          errors++;
          $display("FAIL publish: got %h at cycle %0d expected %h at cycle %0d",
                   location, cyc, mon_e.loc, mon_e.due);
        end
      end
    end
    nd_prev = new_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] idx, input logic [7:0] d);
    sample_valid    = 1'b1;
    sample_index    = idx;
    sample_distance = d;
    tick(1);
    sample_valid = 1'b0;
    last_edge    = cyc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic run_sweep();
    for (int i = 0; i < NS; i++) send(idx_v[i], dist_v[i]);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b0;
    tick(1);
    vsync = 1'b1;
    tick(1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sample_valid = 1'b0;
    sample_distance = 8'd0; sample_index = 4'd0; vsync = 1'b1;
    tick(2);
    reset = 1'b0;
    chk12("reset_location", location, 12'h000);
    chk1("reset_new_data", new_data, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_no_target", no_target, 1'b0);
    chk1("reset_sample_error", sample_error, 1'b0);

    // Nearest echo 60 first seen at index 1; the later tie at index 3 must not win.
    pulse_start();
    chk1("sweep_busy", busy, 1'b1);
    dist_v = '{8'd80, 8'd60, 8'd90, 8'd60, 8'd100, 8'd110,
               8'd120, 8'd130, 8'd140, 8'd150, 8'd170, 8'd200};
    for (int i = 0; i < NS; i++) idx_v[i] = 4'(i);
    run_sweep();
    sb.push_back('{12'h13C, last_edge + 2});
    tick(1);
    chk1("publish_cycle_new_data", new_data, 1'b0);
    tick(1);
    chk1("hold_new_data", new_data, 1'b1);
    chk12("hold_location", location, 12'h13C);
    chk1("hold_busy", busy, 1'b1);
    pulse_start();
    chk1("start_ignored_in_hold", new_data, 1'b1);
    vsync_pulse();
    chk1("hold_after_first_vsync", new_data, 1'b1);
    vsync_pulse();
    chk1("cleared_after_second_vsync", new_data, 1'b0);
    chk1("idle_after_second_vsync", busy, 1'b0);

    // No echoes at all.
    pulse_start();
    for (int i = 0; i < NS; i++) dist_v[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
    run_sweep();
    tick(2);
    chk1("no_target_set", no_target, 1'b1);
    chk1("no_target_new_data", new_data, 1'b0);
    chk12("no_target_location_kept", location, 12'h13C);
    chk1("no_target_idle", busy, 1'b0);

    // Timeout after five samples.
    pulse_start();
    chk1("start_clears_no_target", no_target, 1'b0);
    for (int i = 0; i < 5; i++) send(4'(i), 8'd30);
    tick(TO - 1);
    chk1("timeout_not_yet", sample_error, 1'b0);
    chk1("timeout_still_busy", busy, 1'b1);
    tick(1);
    chk1("timeout_error", sample_error, 1'b1);
    chk1("timeout_idle", busy, 1'b0);
    chk12("timeout_location_kept", location, 12'h13C);

    // Index mismatch discards the closer echo; vsync rise coincides with publish.
    vsync = 1'b0;
    pulse_start();
    chk1("start_clears_error", sample_error, 1'b0);
    for (int i = 0; i < NS; i++) begin
      idx_v[i]  = 4'(i);
      dist_v[i] = 8'd50;
    end
    idx_v[4]  = 4'd7;
    dist_v[4] = 8'd10;
    run_sweep();
    sb.push_back('{12'h032, last_edge + 2});
    tick(1);
    vsync = 1'b1;
    tick(1);
    chk1("mismatch_new_data", new_data, 1'b1);
    chk12("mismatch_location", location, 12'h032);
    chk1("mismatch_error", sample_error, 1'b1);
    vsync_pulse();
    chk1("publish_edge_not_counted", new_data, 1'b1);

    // Reset in HOLD.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk1("reset_hold_new_data", new_data, 1'b0);
    chk12("reset_hold_location", location, 12'h000);
    chk1("reset_hold_busy", busy, 1'b0);
    chk1("reset_hold_error", sample_error, 1'b0);

    // start during SWEEP must not restart the count.
    pulse_start();
    for (int i = 0; i < 3; i++) send(4'(i), 8'd70);
    pulse_start();
    for (int i = 3; i < NS; i++) send(4'(i), (i == 5) ? 8'd40 : 8'd70);
    sb.push_back('{12'h528, last_edge + 2});
    tick(2);
    chk1("restart_ignored_error", sample_error, 1'b0);
    chk12("restart_ignored_location", location, 12'h528);
    send(4'd0, 8'd5);
    chk1("sample_outside_sweep_error", sample_error, 1'b0);
    chk12("sample_outside_sweep_location", location, 12'h528);
    vsync_pulse();
    vsync_pulse();
    chk1("final_idle", busy, 1'b0);

    tick(5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
